// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the Y86 PIPE control unit: icodes, status codes and FSM states.
package pipe_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;

    localparam logic [1:0] S_AOK    = 2'd0;
    localparam logic [1:0] S_HLT    = 2'd1;
    localparam logic [1:0] S_ADR    = 2'd2;
    localparam logic [1:0] S_INS    = 2'd3;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational hazard terms: load/use, return in flight, and mispredicted jump.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [3:0] D_icode_i,
    input  logic [3:0] d_srcA_i,
    input  logic [3:0] d_srcB_i,
    input  logic [3:0] E_icode_i,
    input  logic [3:0] E_dstM_i,
    input  logic       e_Cnd_i,
    input  logic [3:0] M_icode_i,
    output logic       lu_o,
    output logic       rt_o,
    output logic       mp_o
);

    logic e_is_load;

    always_comb begin
        e_is_load = (E_icode_i == I_MRMOVQ) || (E_icode_i == I_POPQ);
        lu_o      = e_is_load && (E_dstM_i != RNONE) &&
                    ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
        rt_o      = (D_icode_i == I_RET) || (E_icode_i == I_RET) || (M_icode_i == I_RET);
        mp_o      = (E_icode_i == I_JXX) && !e_Cnd_i;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/bubble control with reset flush, halt/exception freeze and
// saturating performance counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [1:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             halted,
    output logic [1:0]       final_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       flush_q, flush_d;
    logic [1:0]       final_q, final_d;
    logic [CNT_W-1:0] cycle_q, instr_q, bubble_q;
    logic             lu, rt, mp, exc, active;

    hazard_detect u_hazard (
        .D_icode_i (D_icode),
        .d_srcA_i  (d_srcA),
        .d_srcB_i  (d_srcB),
        .E_icode_i (E_icode),
        .E_dstM_i  (E_dstM),
        .e_Cnd_i   (e_Cnd),
        .M_icode_i (M_icode),
        .lu_o      (lu),
        .rt_o      (rt),
        .mp_o      (mp)
    );

    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        final_d  = final_q;
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        halted   = 1'b0;
        exc      = (m_stat != S_AOK) || (W_stat != S_AOK);
        active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);

        case (state_q)
            ST_INIT: begin
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                if (flush_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_d = flush_q - 4'd1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                F_stall  = lu || rt;
                D_stall  = lu;
                D_bubble = mp || (rt && !lu);
                E_bubble = mp || lu;
                M_bubble = exc || (state_q == ST_DRAIN);
                W_stall  = (W_stat != S_AOK);
                // A faulting writeback wins over a faulting memory stage.
                if (W_stat != S_AOK) begin
                    state_d = ST_HALTED;
                    final_d = W_stat;
                end else if ((state_q == ST_RUN) && (m_stat != S_AOK)) begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
                halted   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INIT;
            flush_q  <= FLUSH_INIT;
            final_q  <= '0;
            cycle_q  <= '0;
            instr_q  <= '0;
            bubble_q <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            final_q <= final_d;
            if (active && (cycle_q != '1)) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (active && (W_stat == S_AOK) && (W_icode != I_NOP) && (instr_q != '1)) begin
                instr_q <= instr_q + CNT_W'(1);
            end
            if (active && (mp || lu) && (bubble_q != '1)) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

    assign final_stat = final_q;
    assign cycle_cnt  = cycle_q;
    assign instr_cnt  = instr_q;
    assign bubble_cnt = bubble_q;

endmodule
